seq_csa_adder: RTL

Iterative, parametrised carry-select adder for the datapath's adder family. It adds two WIDTH-bit operands one BLOCK-bit slice per clock, LSB slice first. For each slice it computes both the carry-in=0 and carry-in=1 results and selects one with the registered carry from the previous slice. A start/ready/done handshake lets a controller issue one addition at a time and read a held result.

---
 rtl/seq_csa_pkg.sv | 22 ++
 rtl/seq_csa_adder_csa_block_select.sv | 27 ++
 rtl/seq_csa_adder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/seq_csa_pkg.sv
// Shared types and constants for the iterative carry-select adder.
package seq_csa_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_BLOCK = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Ceiling log2 that never returns less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    while ((32'sd1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_csa_adder_csa_block_select.sv
// One carry-select slice: both carry-in results are formed, then the incoming carry picks one.
module csa_block_select #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a_i,
  input  logic [BLOCK-1:0] b_i,
  input  logic             sel_i,
  output logic [BLOCK-1:0] sum_o,
  output logic             carry_o
);

  logic [BLOCK:0] sum0_s;
  logic [BLOCK:0] sum1_s;

  always_comb begin
    sum0_s = {1'b0, a_i} + {1'b0, b_i};
    sum1_s = {1'b0, a_i} + {1'b0, b_i} + {{BLOCK{1'b0}}, 1'b1};
    if (sel_i) begin
      sum_o   = sum1_s[BLOCK-1:0];
      carry_o = sum1_s[BLOCK];
    end else begin
      sum_o   = sum0_s[BLOCK-1:0];
      carry_o = sum0_s[BLOCK];
    end
  end

endmodule

// File: rtl/seq_csa_adder.sv
// Iterative carry-select adder, one BLOCK-bit slice per clock, LSB slice first.
// Define SEQ_CSA_OVERFLOW_EN to add the registered signed-overflow output.
module seq_csa_adder
  import seq_csa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int BLOCK = DEFAULT_BLOCK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SEQ_CSA_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int N    = WIDTH / BLOCK;
  localparam int IDXW = clog2_min1(N);
  localparam int LSBW = clog2_min1(WIDTH);

  if (BLOCK < 1 || BLOCK > WIDTH) begin : g_bad_block
    $error("seq_csa_adder: BLOCK must lie in 1..WIDTH");
  end else if ((WIDTH % BLOCK) != 0) begin : g_bad_width
    $error("seq_csa_adder: WIDTH must be a multiple of BLOCK");
  end

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  a_q, b_q, acc_q, acc_d, sum_q;
  logic              carry_q, cout_q, done_q;
  logic [LSBW-1:0]   lsb_s;
  logic [BLOCK-1:0]  a_sl_s, b_sl_s, blk_sum_s;
  logic              blk_carry_s, last_s;
`ifdef SEQ_CSA_OVERFLOW_EN
  logic              ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? RUN : IDLE;
      RUN:     state_d = last_s ? IDLE : RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    case (state_q)
      IDLE:    ready = 1'b1;
      RUN:     ready = 1'b0;
      default: ready = 1'b0;
    endcase
  end

  // Slice selection; lsb_s never exceeds WIDTH-BLOCK so the narrow product is exact.
  always_comb begin
    lsb_s  = LSBW'(idx_q) * LSBW'(BLOCK);
    last_s = (idx_q == IDXW'(N - 1));
    a_sl_s = a_q[lsb_s +: BLOCK];
    b_sl_s = b_q[lsb_s +: BLOCK];
    acc_d  = acc_q;
    acc_d[lsb_s +: BLOCK] = blk_sum_s;
  end

  csa_block_select #(.BLOCK(BLOCK)) u_blk (
    .a_i     (a_sl_s),
    .b_i     (b_sl_s),
    .sel_i   (carry_q),
    .sum_o   (blk_sum_s),
    .carry_o (blk_carry_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_CSA_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          carry_q <= blk_carry_s;
          idx_q   <= idx_q + IDXW'(1);
          if (last_s) begin
            sum_q  <= acc_d;
            cout_q <= blk_carry_s;
            done_q <= 1'b1;
`ifdef SEQ_CSA_OVERFLOW_EN
            // Carry into the MSB is recovered from the MSB's own sum bit.
            ovf_q  <= a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ blk_sum_s[BLOCK-1] ^ blk_carry_s;
`endif
          end
        end
        default: begin
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SEQ_CSA_OVERFLOW_EN
  assign overflow = ovf_q;
`endif

endmodule
